// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one multiplier bit per clock, LSB first,
// full 2*WIDTH-bit product, optional two's-complement mode, valid/ready on both sides.
module seq_mul #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               busy_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P    = PW'(1);

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [PW-1:0]    result_q, result_d;
    logic             sign_q,   sign_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    acc_next;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
    always_comb begin
        a_mag = a_i;
        b_mag = b_i;
        if (SIGNED) begin
            if (a_i[WIDTH-1]) a_mag = ~a_i + ONE_W;
            if (b_i[WIDTH-1]) b_mag = ~b_i + ONE_W;
        end
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // NOTE: every variable gets a hold default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        sign_d   = sign_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    sign_d   = SIGNED && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                end
            end
            S_RUN: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + ONE_C;
                if (cnt_q == LAST_BIT) begin
                    state_d  = S_DONE;
                    result_d = sign_q ? (~acc_next + ONE_P) : acc_next;
                end
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every register, result included, has a reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            sign_q   <= sign_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign result_o    = result_q;

endmodule
